// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the Data_Memory port arbiter.
// Optional statistics outputs are enabled with DMEM_ARB_STATS_EN.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DBG_ACC = 2'd2
    } arb_state_t;

    localparam logic [1:0] WCMD_BYTE = 2'b00;
    localparam logic [1:0] WCMD_HALF = 2'b01;
    localparam logic [1:0] WCMD_WORD = 2'b10;

    localparam int STARVE_LIMIT_DEFAULT = 8;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating 8-bit count of cycles the debug requester has been kept waiting.
// Clear dominates increment; limit_hit flags that debug must win the next grant.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    localparam logic [7:0] LIMIT_8 = 8'(STARVE_LIMIT);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (inc && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign limit_hit = (cnt >= LIMIT_8);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single Data_Memory port: CPU has priority,
// debug is protected from starvation. DMEM_ARB_STATS_EN adds stat_* counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_wcmd,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_wcmd,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_cpu_stall_cycles,
    output logic [15:0]       stat_dbg_grants
`endif
);

    arb_state_t state;
    arb_state_t next_state;
    logic       eff_cpu;
    logic       eff_dbg;
    logic       starve_hit;

    // A requester sitting in its access cycle is done; it must not re-win now.
    assign eff_cpu = cpu_req & (state != CPU_ACC);
    assign eff_dbg = dbg_req & (state != DBG_ACC);

    dmem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk       (clk),
        .resetn    (resetn),
        .inc       (dbg_req & (state != DBG_ACC)),
        .clr       (~dbg_req | (next_state == DBG_ACC)),
        .limit_hit (starve_hit)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = IDLE;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        mem_wcmd   = 2'b00;
        cpu_ack    = 1'b0;
        cpu_rdata  = '0;
        dbg_ack    = 1'b0;
        dbg_rdata  = '0;

        if (starve_hit && eff_dbg) begin
            next_state = DBG_ACC;
        end else if (eff_cpu) begin
            next_state = CPU_ACC;
        end else if (eff_dbg) begin
            next_state = DBG_ACC;
        end

        case (state)
            CPU_ACC: begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
                mem_wcmd  = cpu_wcmd;
                cpu_ack   = 1'b1;
                cpu_rdata = mem_rdata;
            end
            DBG_ACC: begin
                mem_addr  = dbg_addr;
                mem_we    = dbg_we;
                mem_wdata = dbg_wdata;
                mem_wcmd  = WCMD_WORD;
                dbg_ack   = 1'b1;
                dbg_rdata = mem_rdata;
            end
            default: ;
        endcase
    end

    // Gated by resetn so every output is low while reset is held.
    assign cpu_stall = resetn & cpu_req & ~cpu_ack;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_cpu_stall_cycles <= 32'd0;
            stat_dbg_grants       <= 16'd0;
        end else begin
            if (cpu_stall) begin
                stat_cpu_stall_cycles <= stat_cpu_stall_cycles + 32'd1;
            end
            if (state == DBG_ACC) begin
                stat_dbg_grants <= stat_dbg_grants + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run against a grant/memory reference model. Define DMEM_ARB_STATS_EN for stats.
module tb_dmem_arbiter;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [1:0]  cpu_wcmd = '0;
    logic        cpu_ack, cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = '0, dbg_wdata = '0;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [1:0]  mem_wcmd;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_cpu_stall_cycles;
    logic [15:0] stat_dbg_grants;
`endif

    int checks = 0;
    int passes = 0;

    // Memory behind the port, plus a backdoor for preloading
    logic [31:0] env_mem [64] = '{default: 32'h0};
    logic [31:0] gold    [64] = '{default: 32'h0};
    logic        bd_we = 1'b0;
    logic [5:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] cmd, input logic [1:0] lo);
        logic [31:0] r;
        r = old;
        case (cmd)
            2'b00:   r[8*lo +: 8] = wd[7:0];
            2'b01:   r[16*lo[1] +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [133:0] pack(input logic ca, input logic cs, input logic da,
                                          input logic we, input logic [1:0] cmd,
                                          input logic [31:0] a, input logic [31:0] wd,
                                          input logic [31:0] crd, input logic [31:0] drd);
        return {ca, cs, da, we, cmd, a, wd, crd, drd};
    endfunction

    always @(posedge clk) begin
        if (bd_we) env_mem[bd_idx] <= bd_data;
        else if (mem_we) env_mem[mem_addr[7:2]] <= merge(env_mem[mem_addr[7:2]], mem_wdata, mem_wcmd, mem_addr[1:0]);
    end

    assign mem_rdata = env_mem[mem_addr[7:2]];

    logic [133:0] act_v;
    assign act_v = pack(cpu_ack, cpu_stall, dbg_ack, mem_we, mem_wcmd, mem_addr, mem_wdata, cpu_rdata, dbg_rdata);

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wcmd  (cpu_wcmd),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_wcmd  (mem_wcmd),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_cpu_stall_cycles (stat_cpu_stall_cycles),
        .stat_dbg_grants       (stat_dbg_grants)
`endif
    );

    task automatic bd_write(input logic [5:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        bd_we = 1'b1; bd_idx = idx; bd_data = data;
        @(posedge clk); #1;
        bd_we = 1'b0;
        gold[idx] = data;
    endtask

    task automatic idle_cycles(input int n);
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [133:0] exp_v;
        cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b1; dbg_we = 1'b1;
        repeat (2) @(negedge clk);
        exp_v = '0;
        checks++;
        if (act_v !== exp_v) $display("FAIL reset_hold: got %h expected %h", act_v, exp_v);
        else passes++;
        cpu_req = 1'b0; dbg_req = 1'b0; cpu_we = 1'b0; dbg_we = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (act_v !== exp_v) $display("FAIL reset_release: got %h expected %h", act_v, exp_v);
        else passes++;
    endtask

    task automatic test_cpu_load;
        logic [133:0] exp_v;
        bd_write(6'h04, 32'hDEADBEEF);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = '0; cpu_wcmd = 2'b00;
        @(negedge clk);
        exp_v = pack(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (act_v !== exp_v) $display("FAIL load_stall: got %h expected %h", act_v, exp_v);
        else passes++;
        @(negedge clk);
        exp_v = pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0);
        checks++;
        if (act_v !== exp_v) $display("FAIL load_ack: got %h expected %h", act_v, exp_v);
        else passes++;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        exp_v = '0;
        checks++;
        if (act_v !== exp_v) $display("FAIL load_done: got %h expected %h", act_v, exp_v);
        else passes++;
    endtask

    task automatic test_cpu_store_dbg_read;
        logic [133:0] exp_v;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678; cpu_wcmd = 2'b10;
        @(negedge clk);
        exp_v = pack(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (act_v !== exp_v) $display("FAIL store_stall: got %h expected %h", act_v, exp_v);
        else passes++;
        @(negedge clk);
        exp_v = pack(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h20, 32'h12345678, gold[8], 32'h0);
        checks++;
        if (act_v !== exp_v) $display("FAIL store_ack: got %h expected %h", act_v, exp_v);
        else passes++;
        gold[8] = 32'h12345678;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) $display("FAIL store_we_once: got %b expected 0", mem_we);
        else passes++;
        @(posedge clk); #1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20; dbg_wdata = 32'h0;
        @(negedge clk);
        exp_v = '0;
        checks++;
        if (act_v !== exp_v) $display("FAIL dbg_wait: got %h expected %h", act_v, exp_v);
        else passes++;
        @(negedge clk);
        exp_v = pack(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 32'h20, 32'h0, 32'h0, 32'h12345678);
        checks++;
        if (act_v !== exp_v) $display("FAIL dbg_read: got %h expected %h", act_v, exp_v);
        else passes++;
        @(posedge clk); #1;
        dbg_req = 1'b0;
    endtask

    task automatic test_simultaneous;
        bit ca [6] = '{0, 1, 0, 1, 0, 1};
        bit da [6] = '{0, 0, 1, 0, 0, 0};
        bit st [6] = '{1, 0, 1, 0, 1, 0};
        logic [2:0] exp3, act3;
        int dbg_ack_cyc;
        dbg_ack_cyc = 99;
        @(posedge clk); #1;
        cpu_we = 1'b0; cpu_addr = 32'h10; dbg_we = 1'b0; dbg_addr = 32'h20;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            cpu_req = 1'b1;
            dbg_req = (k < 3);
            @(negedge clk);
            exp3 = {ca[k], da[k], st[k]};
            act3 = {cpu_ack, dbg_ack, cpu_stall};
            checks++;
            if (act3 !== exp3) $display("FAIL simul_cyc%0d: got %b expected %b", k, act3, exp3);
            else passes++;
            if (dbg_ack && dbg_ack_cyc == 99) dbg_ack_cyc = k + 1;
        end
        checks++;
        if (dbg_ack_cyc > 9) $display("FAIL simul_dbg_latency: got %0d expected <= 9", dbg_ack_cyc);
        else passes++;
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_store;
        logic [133:0] exp_v;
        bd_write(6'h0C, 32'h0BADF00D);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hA5A5A5A5; cpu_wcmd = 2'b10;
        @(posedge clk); #1;
        exp_v = pack(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h30, 32'hA5A5A5A5, 32'h0BADF00D, 32'h0);
        checks++;
        if (act_v !== exp_v) $display("FAIL rst_pre_acc: got %h expected %h", act_v, exp_v);
        else passes++;
        resetn = 1'b0;
        #1;
        checks++;
        if (act_v !== '0) $display("FAIL rst_async_drop: got %h expected 0", act_v);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if (env_mem[12] !== 32'h0BADF00D) $display("FAIL rst_write_dropped: got %h expected 0badf00d", env_mem[12]);
        else passes++;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        exp_v = pack(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
        checks++;
        if (act_v !== exp_v) $display("FAIL rst_post_release: got %h expected %h", act_v, exp_v);
        else passes++;
        @(posedge clk); #1;
        exp_v = pack(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h30, 32'hA5A5A5A5, 32'h0BADF00D, 32'h0);
        checks++;
        if (act_v !== exp_v) $display("FAIL rst_first_grant: got %h expected %h", act_v, exp_v);
        else passes++;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        gold[12] = 32'hA5A5A5A5;
        checks++;
        if (env_mem[12] !== 32'hA5A5A5A5) $display("FAIL rst_retry_write: got %h expected a5a5a5a5", env_mem[12]);
        else passes++;
        idle_cycles(2);
    endtask

    task automatic test_random;
        int          m_grant, m_cnt, nx, wait_c, max_wait;
        bit          cpu_done, dbg_done, eff_c, eff_d;
        logic [133:0] exp_v;
        m_grant = 0; m_cnt = 0; wait_c = 0; max_wait = 0;
        cpu_done = 1'b0; dbg_done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (!cpu_req || cpu_done) begin
                cpu_req   = ($urandom_range(0, 3) != 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = $urandom;
                cpu_wdata = $urandom;
                cpu_wcmd  = 2'($urandom_range(0, 2));
            end
            if (!dbg_req || dbg_done) begin
                dbg_req   = ($urandom_range(0, 2) == 0);
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = $urandom & 32'hFFFF_FFFC;
                dbg_wdata = $urandom;
            end
            @(negedge clk);
            case (m_grant)
                1: exp_v = pack(1'b1, 1'b0, 1'b0, cpu_we, cpu_wcmd, cpu_addr, cpu_wdata, gold[cpu_addr[7:2]], 32'h0);
                2: exp_v = pack(1'b0, cpu_req, 1'b1, dbg_we, 2'b10, dbg_addr, dbg_wdata, 32'h0, gold[dbg_addr[7:2]]);
                default: exp_v = pack(1'b0, cpu_req, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
            endcase
            checks++;
            if (act_v !== exp_v) $display("FAIL random_cyc%0d: got %h expected %h", i, act_v, exp_v);
            else passes++;
            if (m_grant == 1 && cpu_we) gold[cpu_addr[7:2]] = merge(gold[cpu_addr[7:2]], cpu_wdata, cpu_wcmd, cpu_addr[1:0]);
            if (m_grant == 2 && dbg_we) gold[dbg_addr[7:2]] = dbg_wdata;
            wait_c = (dbg_req && m_grant != 2) ? wait_c + 1 : 0;
            if (wait_c > max_wait) max_wait = wait_c;
            cpu_done = (m_grant == 1);
            dbg_done = (m_grant == 2);
            // Served requester is finished this cycle; pick next grant from the rest
            eff_c = cpu_req && (m_grant != 1);
            eff_d = dbg_req && (m_grant != 2);
            if (eff_d && m_cnt >= LIMIT) nx = 2;
            else if (eff_c) nx = 1;
            else if (eff_d) nx = 2;
            else nx = 0;
            if (!dbg_req || nx == 2) m_cnt = 0;
            else if (m_grant != 2 && m_cnt < 255) m_cnt = m_cnt + 1;
            m_grant = nx;
        end
        checks++;
        if (max_wait > 9) $display("FAIL random_dbg_latency: got %0d expected <= 9", max_wait);
        else passes++;
        idle_cycles(2);
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats;
        resetn = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0; cpu_we = 1'b0; dbg_we = 1'b0;
        cpu_addr = '0; dbg_addr = '0;
        @(posedge clk); #1;
        resetn = 1'b1;
        cpu_req = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        cpu_req = 1'b0;
        dbg_req = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        dbg_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (stat_cpu_stall_cycles !== 32'd5) $display("FAIL stat_stalls: got %0d expected 5", stat_cpu_stall_cycles);
        else passes++;
        checks++;
        if (stat_dbg_grants !== 16'd2) $display("FAIL stat_dbg_grants: got %0d expected 2", stat_dbg_grants);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_load();
        test_cpu_store_dbg_read();
        test_simultaneous();
        test_reset_mid_store();
        test_random();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
